serial_result_receiver: RTL and testbench
=========================================

Name: serial_result_receiver

Overview:
- Receiving end of the serial-adder result link.
- Consumes the LSB-first serial word and its start pulse that the adder datapath's PISO stage emits.
- Reassembles each word into parallel form and buffers up to 2 words.
- Hands words downstream over a valid/ready handshake, with protocol-error, overrun and frame-count status.

Parameters:
- WIDTH, 5, bits per serial word (min 2).
- DEPTH, 2, output buffer entries (fixed at 2).
- CNT_W, 8, width of frame_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle frame start; coincides with bit 0 on serial_in.
- serial_in  input  1  serial data, LSB first, one bit per cycle.
- data_out  output  WIDTH  head-of-buffer word.
- valid_out  output  1  data_out holds a word.
- ready_in  input  1  downstream accepts; pop when valid_out && ready_in.
- busy  output  1  frame assembly in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse: start_in seen mid-frame.
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.
- frame_count  output  CNT_W  count of words accepted into the buffer.

Behaviour:
- Reset (reset=0, async):
  - State IDLE, bit counter 0, shift register 0, buffer empty.
  - data_out=0, valid_out=0, busy=0, frame_err=0, overrun=0, frame_count=0.
  - A partial frame is discarded; no word is delivered for it after release.
- IDLE:
  - start_in=1: sample serial_in into bit 0, bit_cnt<=1, go SHIFT.
  - serial_in is ignored without start_in.
- SHIFT:
  - Each cycle, sample serial_in into bit[bit_cnt] and increment bit_cnt.
  - On the edge sampling bit WIDTH-1: push the word to the buffer and return to IDLE.
- Latency: start_in at cycle 0, last bit at cycle WIDTH-1. With the buffer previously empty, valid_out=1 and data_out=word in cycle WIDTH.
- Back-to-back frames: start_in in cycle WIDTH (zero gap) is legal and begins the next frame.
- start_in while in SHIFT (any bit index 1..WIDTH-1):
  - Partial word discarded.
  - frame_err pulses one cycle.
  - The current serial_in is taken as bit 0 of a new frame; stay in SHIFT with bit_cnt=1.
- Buffer:
  - 2-entry FIFO, first-in first-out.
  - data_out is stable while valid_out && !ready_in.
- Push when full with no pop in the same cycle:
  - Word dropped, overrun pulses one cycle.
  - frame_count unchanged, buffer contents unchanged.
- Push and pop in the same cycle when full: the pop frees a slot, so the push is accepted with no overrun.
- Pop when empty: ignored.
- frame_count increments by 1 per accepted push and wraps from 2^CNT_W-1 to 0.
- Outputs are registered; no combinational path from start_in/serial_in to outputs.

Decomposition:
- Shared package/defines: state encoding (IDLE, SHIFT) and default WIDTH=5. The same WIDTH constant is used by the adder datapath so that both ends agree.
- One sub-module: result_fifo (2-entry, WIDTH-wide, push/pop/full/empty).
- The receiver FSM and shift register stay in the top module.

Test Plan:
- Frame bits 1,0,1,1,0 (LSB first), ready_in=1 -> valid_out rises in cycle 5, data_out=5'd13, frame_count=1, frame_err=0.
- Frames 13 then 31 back-to-back with ready_in=0 -> valid_out=1 and data_out=13 held. Then ready_in=1 -> pops 13 then 31 on consecutive cycles, frame_count=2.
- Third frame (5'd7) while the buffer is full and ready_in=0 -> overrun pulses once, buffer still 13,31, frame_count=2. Repeat with ready_in=1 in the completion cycle -> no overrun, order 13,31,7, frame_count=3.
- start_in reasserted at bit 3 of a frame, then new bits 0,1,0,0,1 -> frame_err one pulse, only 5'd18 delivered.
- reset=0 asynchronously at bit 2 -> all outputs 0 before the next edge. After release, with no further start_in, valid_out stays 0.
- 256 accepted frames -> frame_count wraps to 0 with no spurious overrun.

Source files
------------

// File: rtl/serial_result_receiver_pkg.sv
// Shared constants and state encoding for the serial result link.
// RESULT_WIDTH is also used by the adder datapath so both ends agree on the word size.
package serial_result_receiver_pkg;

  localparam int RESULT_WIDTH = 5;
  localparam int RESULT_DEPTH = 2;
  localparam int RESULT_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rxState_t;

endpackage

// File: rtl/serial_result_receiver_result_fifo.sv
// Two-entry result buffer. entry0 is always the head, so the head word is a plain
// register and stays put while nothing is popped.
module result_fifo
  import serial_result_receiver_pkg::*;
#(
  parameter int WIDTH = RESULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] headData,
  output logic             accepted,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic [1:0]       count;
  logic             popOk;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign popOk    = pop && !empty;
  // A pop in the same cycle frees a slot, so a full buffer can still take the push.
  assign accepted = push && (!full || popOk);
  assign headData = entry0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({accepted, popOk})
        2'b10: begin
          if (empty) entry0 <= pushData;
          else       entry1 <= pushData;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          entry1 <= '0;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (full) begin
            entry0 <= entry1;
            entry1 <= pushData;
          end else begin
            entry0 <= pushData;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial_result_receiver.sv
// Receiving end of the serial-adder result link: reassembles LSB-first serial words,
// buffers them in result_fifo and hands them downstream over valid/ready.
module serial_result_receiver
  import serial_result_receiver_pkg::*;
#(
  parameter int WIDTH = RESULT_WIDTH,
  parameter int DEPTH = RESULT_DEPTH,
  parameter int CNT_W = RESULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_count
);

  localparam int BCW = $clog2(WIDTH);

  rxState_t         state;
  rxState_t         nextState;
  logic [BCW-1:0]   bitCnt;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] wordOut;
  logic             lastBit;
  logic             pushWord;
  logic             popWord;
  logic             accepted;
  logic             fifoFull;
  logic             fifoEmpty;

  assign lastBit = (bitCnt == BCW'(WIDTH - 1));
  // The final bit goes straight into the buffer on the edge that samples it.
  assign wordOut = {serial_in, shiftReg[WIDTH-2:0]};
  assign popWord = valid_out && ready_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    pushWord  = 1'b0;
    case (state)
      IDLE:  if (start_in) nextState = SHIFT;
      SHIFT: begin
        if (start_in) begin
          nextState = SHIFT;
        end else if (lastBit) begin
          nextState = IDLE;
          pushWord  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shiftReg    <= '0;
      bitCnt      <= '0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_err <= (state == SHIFT) && start_in;
      overrun   <= pushWord && !accepted;
      if (accepted) frame_count <= frame_count + CNT_W'(1);
      // A start always restarts assembly, discarding any partial word.
      if (start_in) begin
        shiftReg <= {{(WIDTH-1){1'b0}}, serial_in};
        bitCnt   <= BCW'(1);
      end else if (state == SHIFT) begin
        shiftReg[bitCnt] <= serial_in;
        bitCnt           <= lastBit ? '0 : bitCnt + BCW'(1);
      end
    end
  end

  result_fifo #(.WIDTH(WIDTH)) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushWord),
    .pop      (popWord),
    .pushData (wordOut),
    .headData (data_out),
    .accepted (accepted),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign valid_out = !fifoEmpty;
  assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_serial_result_receiver.sv
// Self-checking bench: a frame/queue model predicts every output each cycle, and
// directed scenarios pin delivered words and counters to hand-computed values.
module tb_serial_result_receiver;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_in = 1'b0;
  logic         serial_in = 1'b0;
  logic         ready_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         busy;
  logic         frame_err;
  logic         overrun;
  logic [7:0]   frame_count;

  int checks = 0;
  int errors = 0;

  serial_result_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .start_in    (start_in),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: collected bits of the frame in progress, and the buffered words.
  int           bits[$];
  logic [W-1:0] expQ[$];
  int           expCount;
  bit           expErr;
  bit           expOvr;
  bit           mPop;
  logic [W-1:0] mWord;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits.delete();
      expQ.delete();
      expCount = 0;
      expErr = 0;
      expOvr = 0;
    end else begin
      mPop = (expQ.size() > 0) && ready_in;
      expErr = 0;
      expOvr = 0;
      if (start_in) begin
        if (bits.size() > 0) expErr = 1;
        bits.delete();
        bits.push_back(int'(serial_in));
      end else if (bits.size() > 0) begin
        bits.push_back(int'(serial_in));
      end
      if (mPop) void'(expQ.pop_front());
      if (bits.size() == W) begin
        mWord = '0;
        for (int i = 0; i < W; i++) mWord[i] = bits[i][0];
        if (expQ.size() < 2) begin
          expQ.push_back(mWord);
          expCount = (expCount + 1) % 256;
        end else begin
          expOvr = 1;
        end
        bits.delete();
      end
    end
  end

  // Words actually handed off by the DUT, and its status pulse tallies.
  logic [W-1:0] dutPopQ[$];
  int errPulses = 0;
  int ovrPulses = 0;

  always @(posedge clk) begin
    if (reset && valid_out && ready_in) dutPopQ.push_back(data_out);
  end

  always @(negedge clk) begin
    if (reset) begin
      check("valid_out", int'(valid_out), int'(expQ.size() > 0));
      if (expQ.size() > 0) check("data_out", int'(data_out), int'(expQ[0]));
      check("busy", int'(busy), int'(bits.size() > 0));
      check("frame_err", int'(frame_err), int'(expErr));
      check("overrun", int'(overrun), int'(expOvr));
      check("frame_count", int'(frame_count), expCount);
      if (frame_err) errPulses++;
      if (overrun) ovrPulses++;
    end
  end

  task automatic bitCycle(input logic s, input logic b);
    @(negedge clk);
    start_in  = s;
    serial_in = b;
  endtask

  task automatic sendWord(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) bitCycle(i == 0, w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bitCycle(1'b0, 1'b0);
  endtask

  task automatic checkPop(input string name, input int idx, input int exp);
    if (idx < dutPopQ.size()) check(name, int'(dutPopQ[idx]), exp);
    else check(name, -1, exp);
  endtask

  int base;
  int errBase;
  int ovrBase;
  logic [W-1:0] seqWord;

  initial begin
    // Reset state
    #2;
    check("rst_valid", int'(valid_out), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(frame_count), 0);
    check("rst_pulses", int'(frame_err) + int'(overrun), 0);
    @(negedge clk);
    reset = 1'b1;

    // Single frame 1,0,1,1,0 -> 13, visible in cycle WIDTH
    ready_in = 1'b1;
    base = dutPopQ.size();
    sendWord(5'd13);
    idle(1);
    check("t1_valid_c5", int'(valid_out), 1);
    check("t1_data_c5", int'(data_out), 13);
    check("t1_count", int'(frame_count), 1);
    idle(2);
    checkPop("t1_pop0", base, 13);
    check("t1_err", errPulses, 0);

    // Two back-to-back frames held, then drained in order
    ready_in = 1'b0;
    base = dutPopQ.size();
    sendWord(5'd13);
    sendWord(5'd31);
    idle(2);
    check("t2_hold_valid", int'(valid_out), 1);
    check("t2_hold_data", int'(data_out), 13);
    ready_in = 1'b1;
    idle(3);
    checkPop("t2_pop0", base, 13);
    checkPop("t2_pop1", base + 1, 31);
    check("t2_count", int'(frame_count), 3);

    // Third frame into a full buffer is dropped
    ready_in = 1'b0;
    ovrBase = ovrPulses;
    base = dutPopQ.size();
    sendWord(5'd13);
    sendWord(5'd31);
    sendWord(5'd7);
    idle(2);
    check("t3_ovr", ovrPulses - ovrBase, 1);
    check("t3_count", int'(frame_count), 5);
    check("t3_head", int'(data_out), 13);
    ready_in = 1'b1;
    idle(3);
    check("t3_npop", dutPopQ.size() - base, 2);
    checkPop("t3_pop1", base + 1, 31);

    // Same, but a pop coincides with the completing push
    ready_in = 1'b0;
    ovrBase = ovrPulses;
    base = dutPopQ.size();
    sendWord(5'd13);
    sendWord(5'd31);
    seqWord = 5'd7;
    for (int i = 0; i < W; i++) begin
      bitCycle(i == 0, seqWord[i]);
      if (i == W - 1) ready_in = 1'b1;
    end
    idle(4);
    check("t3b_ovr", ovrPulses - ovrBase, 0);
    checkPop("t3b_pop0", base, 13);
    checkPop("t3b_pop1", base + 1, 31);
    checkPop("t3b_pop2", base + 2, 7);
    check("t3b_count", int'(frame_count), 8);

    // Restart at bit 3; only the new frame 0,1,0,0,1 = 18 survives
    errBase = errPulses;
    base = dutPopQ.size();
    bitCycle(1'b1, 1'b1);
    bitCycle(1'b0, 1'b0);
    bitCycle(1'b0, 1'b1);
    bitCycle(1'b1, 1'b0);
    bitCycle(1'b0, 1'b1);
    bitCycle(1'b0, 1'b0);
    bitCycle(1'b0, 1'b0);
    bitCycle(1'b0, 1'b1);
    idle(3);
    check("t4_err", errPulses - errBase, 1);
    check("t4_npop", dutPopQ.size() - base, 1);
    checkPop("t4_word", base, 18);
    check("t4_count", int'(frame_count), 9);

    // Async reset mid-frame with a word buffered
    ready_in = 1'b0;
    sendWord(5'd13);
    bitCycle(1'b1, 1'b1);
    bitCycle(1'b0, 1'b0);
    bitCycle(1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t5_valid", int'(valid_out), 0);
    check("t5_data", int'(data_out), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_count", int'(frame_count), 0);
    @(negedge clk);
    start_in = 1'b0;
    serial_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) bitCycle(1'b0, 1'b1);
    check("t5_no_word", int'(valid_out), 0);
    check("t5_busy_after", int'(busy), 0);

    // frame_count wrap
    ovrBase = ovrPulses;
    for (int i = 0; i < 255; i++) begin
      seqWord = W'(i);
      sendWord(seqWord);
    end
    idle(2);
    check("t6_count255", int'(frame_count), 255);
    sendWord(5'd21);
    idle(2);
    check("t6_wrap", int'(frame_count), 0);
    check("t6_ovr", ovrPulses - ovrBase, 0);
    checkPop("t6_last", dutPopQ.size() - 1, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
